// File: rtl/sonar_env_pkg.sv
// Shared types and constants for the sonar envelope decimator.
//   env_state_t : FSM states (ACCUM collects a window, EMIT holds the result)
//   SAMPLE_W    : width of the incoming filtered sample / outgoing envelope
//   USER_W      : width of the FIR mode tag carried in tuser
//   MAG_MAX     : saturated magnitude used for the most negative sample
package sonar_env_pkg;
    typedef enum logic {ACCUM, EMIT} env_state_t;

    localparam int SAMPLE_W = 32;
    localparam int USER_W   = 2;

    localparam logic [SAMPLE_W-1:0] MAG_MAX = 32'h7FFF_FFFF;
endpackage

// File: rtl/env_abs_sat.sv
// Combinational saturating absolute value of a two's complement sample.
//   x   : signed input sample
//   mag : |x|, with the most negative value clamped to MAG_MAX so the result
//         always fits in SAMPLE_W-1 bits
module env_abs_sat
    import sonar_env_pkg::*;
(
    input  logic [SAMPLE_W-1:0] x,
    output logic [SAMPLE_W-1:0] mag
);
    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};

    always_comb begin
        mag = x;
        if (x == MOST_NEG) begin
            // Negating the most negative value would wrap back to itself.
            mag = MAG_MAX;
        end else if (x[SAMPLE_W-1]) begin
            mag = ~x + 1'b1;
        end
    end
endmodule

// File: rtl/sonar_envelope_decim.sv
// Envelope decimator: rectifies filtered samples, averages 2**LOG2_DECIM of
// them per window and emits one mean-magnitude word per window on AXI-Stream.
// The FIR mode tag of the window is forwarded with the result; a tag change
// inside a window discards the partial window and restarts with the new tag.
//   clk, rstn                  : clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready : filtered signed samples in
//   s_axis_tuser               : mode tag from the FIR
//   m_axis_tdata/tvalid/tready : unsigned mean |x| per window out
//   m_axis_tuser               : mode tag of the emitted window
//   m_axis_tpeak               : max |x| of the window (only with ENV_PEAK_EN)
// Optional feature macro: ENV_PEAK_EN.
module sonar_envelope_decim
    import sonar_env_pkg::*;
#(
    parameter int LOG2_DECIM = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [SAMPLE_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [USER_W-1:0]   s_axis_tuser,
    output logic [SAMPLE_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
`ifdef ENV_PEAK_EN
    output logic [SAMPLE_W-1:0] m_axis_tpeak,
`endif
    input  logic                m_axis_tready,
    output logic [USER_W-1:0]   m_axis_tuser
);
    // The sum of 2**LOG2_DECIM magnitudes below 2**31 cannot overflow this.
    localparam int ACC_W = SAMPLE_W + LOG2_DECIM;
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;
    localparam logic [LOG2_DECIM-1:0] CNT_ONE  = LOG2_DECIM'(1);

    env_state_t            state_reg, state_next;
    logic [ACC_W-1:0]      acc_reg, acc_next;
    logic [LOG2_DECIM-1:0] cnt_reg, cnt_next;
    logic [USER_W-1:0]     win_user_reg, win_user_next;
    logic [SAMPLE_W-1:0]   out_data_reg, out_data_next;
    logic [USER_W-1:0]     out_user_reg, out_user_next;

    logic [SAMPLE_W-1:0]   mag;
    logic [ACC_W-1:0]      sum;
    logic                  accept;

    env_abs_sat u_abs (
        .x   (s_axis_tdata),
        .mag (mag)
    );

    assign sum    = acc_reg + ACC_W'(mag);
    // Gated with rstn so nothing appears accepted while reset is held.
    assign s_axis_tready = rstn && (state_reg == ACCUM);
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = (state_reg == EMIT);
    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tuser  = out_user_reg;

`ifdef ENV_PEAK_EN
    logic [SAMPLE_W-1:0] win_peak_reg, win_peak_next;
    logic [SAMPLE_W-1:0] out_peak_reg, out_peak_next;
    logic [SAMPLE_W-1:0] peak_upd;

    // Running maximum including the sample currently being accepted.
    assign peak_upd     = (mag > win_peak_reg) ? mag : win_peak_reg;
    assign m_axis_tpeak = out_peak_reg;
`endif

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        win_user_next = win_user_reg;
        out_data_next = out_data_reg;
        out_user_next = out_user_reg;
`ifdef ENV_PEAK_EN
        win_peak_next = win_peak_reg;
        out_peak_next = out_peak_reg;
`endif
        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    if ((cnt_reg != '0) && (s_axis_tuser != win_user_reg)) begin
                        // Mode changed mid-window: the new sample starts a fresh
                        // window, even if it would have been the last one.
                        acc_next      = ACC_W'(mag);
                        cnt_next      = CNT_ONE;
                        win_user_next = s_axis_tuser;
`ifdef ENV_PEAK_EN
                        win_peak_next = mag;
`endif
                    end else if (cnt_reg == CNT_LAST) begin
                        out_data_next = sum[ACC_W-1:LOG2_DECIM];
                        out_user_next = win_user_reg;
                        acc_next      = '0;
                        cnt_next      = '0;
                        state_next    = EMIT;
`ifdef ENV_PEAK_EN
                        out_peak_next = peak_upd;
                        win_peak_next = '0;
`endif
                    end else begin
                        acc_next = sum;
                        cnt_next = cnt_reg + 1'b1;
                        if (cnt_reg == '0) begin
                            win_user_next = s_axis_tuser;
                        end
`ifdef ENV_PEAK_EN
                        win_peak_next = peak_upd;
`endif
                    end
                end
            end
            EMIT: begin
                if (m_axis_tready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= ACCUM;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            win_user_reg <= '0;
            out_data_reg <= '0;
            out_user_reg <= '0;
`ifdef ENV_PEAK_EN
            win_peak_reg <= '0;
            out_peak_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            win_user_reg <= win_user_next;
            out_data_reg <= out_data_next;
            out_user_reg <= out_user_next;
`ifdef ENV_PEAK_EN
            win_peak_reg <= win_peak_next;
            out_peak_reg <= out_peak_next;
`endif
        end
    end
endmodule
